dot_prod_ctrl: RTL and testbench

- Host-facing sequencer for the generated dot-product core `main` and its two on-chip arrays (`arr_a`, `arr_b`).
- Accepts a command (length, initial accumulator) and streams element pairs into both arrays through the core's controlArr ports.
- Starts the core, waits for completion with a watchdog, and returns the 64-bit result on a valid/ready channel.
- Sits between the host interconnect and one `main` instance; owns every control input of that instance.

---
 rtl/dot_prod_pkg.sv | 26 ++
 rtl/dot_prod_watchdog.sv | 26 ++
 rtl/dot_prod_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dot_prod_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_prod_pkg.sv
// Shared types and constants for the dot-product core sequencer.
// The core loop runs index i from init_i up to N-1 over arrays arr_a/arr_b.
package dot_prod_pkg;

  localparam int N  = 1000;
  localparam int AW = 10;
  localparam int DW = 27;
  localparam int RW = 64;

  typedef logic signed [DW-1:0] elem_t;
  typedef logic signed [RW-1:0] acc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Lengths above the array depth are clamped so base never underflows.
  function automatic logic [AW:0] sat_len(input logic [AW:0] len);
    return (len > (AW+1)'(N)) ? (AW+1)'(N) : len;
  endfunction

endpackage

// File: rtl/dot_prod_watchdog.sv
// Clearable up-counter that stops at TMO-1 and flags terminal count there.
module dot_prod_watchdog #(
  parameter int TMO = 16384
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TMO) + 1;

  logic [CW-1:0] cnt_q;

  assign tc_o = (cnt_q == CW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dot_prod_ctrl.sv
// Host-facing sequencer: loads element pairs into the core arrays, starts the
// core, waits for completion under a watchdog, and returns the result.
module dot_prod_ctrl
  import dot_prod_pkg::*;
#(
  parameter int TMO = 16384
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AW:0]          cmd_len,
  input  logic signed [RW-1:0] cmd_acc,
  input  logic                 elem_valid,
  output logic                 elem_ready,
  input  logic signed [DW-1:0] elem_a,
  input  logic signed [DW-1:0] elem_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [RW-1:0] res_data,
  output logic                 res_tmo,
  output logic                 core_r_enable,
  output logic                 core_control_arr,
  output logic [AW-1:0]        core_init_i,
  output logic signed [RW-1:0] core_init_acc,
  output logic                 core_we_a,
  output logic                 core_we_b,
  output logic [AW-1:0]        core_addr_a,
  output logic [AW-1:0]        core_addr_b,
  output logic signed [DW-1:0] core_wdata_a,
  output logic signed [DW-1:0] core_wdata_b,
  input  logic                 core_w_enable,
  input  logic signed [RW-1:0] core_result,
  output state_t               state_o
);

  // All channels use valid/ready: a transfer happens on a rising clk edge where
  // both are high; the producer holds its payload stable until that edge.

  state_t        state_q;
  logic [AW:0]   len_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] base_q;
  acc_t          acc_q;
  logic          cmd_ready_q;
  logic          elem_ready_q;
  logic          ctrl_arr_q;
  logic          r_en_q;
  logic          res_valid_q;
  acc_t          res_data_q;
  logic          res_tmo_q;

  logic [AW:0]   len_sat;
  logic [AW-1:0] base_new;
  logic [AW:0]   count_inc;
  logic [AW-1:0] wr_addr;
  logic          elem_hs;
  logic          wd_tc;

  assign len_sat   = sat_len(cmd_len);
  assign base_new  = AW'(N) - len_sat[AW-1:0];
  assign count_inc = count_q + 1'b1;
  assign wr_addr   = base_q + count_q[AW-1:0];
  assign elem_hs   = elem_valid && elem_ready_q;

  dot_prod_watchdog #(.TMO(TMO)) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_START),
    .en_i  (state_q == ST_WAIT),
    .tc_o  (wd_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      count_q      <= '0;
      base_q       <= '0;
      acc_q        <= '0;
      cmd_ready_q  <= 1'b1;
      elem_ready_q <= 1'b0;
      ctrl_arr_q   <= 1'b1;
      r_en_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_tmo_q    <= 1'b0;
    end else begin
      r_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            len_q       <= len_sat;
            acc_q       <= cmd_acc;
            base_q      <= base_new;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
            if (len_sat == '0) begin
              state_q    <= ST_START;
              ctrl_arr_q <= 1'b0;
              r_en_q     <= 1'b1;
            end else begin
              state_q      <= ST_LOAD;
              elem_ready_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (elem_hs) begin
            count_q <= count_inc;
            if (count_inc == len_q) begin
              state_q      <= ST_START;
              elem_ready_q <= 1'b0;
              ctrl_arr_q   <= 1'b0;
              r_en_q       <= 1'b1;
            end
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (core_w_enable) begin
            res_data_q  <= core_result;
            res_tmo_q   <= 1'b0;
            res_valid_q <= 1'b1;
            ctrl_arr_q  <= 1'b1;
            state_q     <= ST_DONE;
          end else if (wd_tc) begin
            res_data_q  <= '0;
            res_tmo_q   <= 1'b1;
            res_valid_q <= 1'b1;
            ctrl_arr_q  <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Array writes follow the element handshake combinationally so no pair is
  // delayed; the bus is zeroed whenever no write happens.
  assign core_we_a    = elem_hs;
  assign core_we_b    = elem_hs;
  assign core_addr_a  = elem_hs ? wr_addr : '0;
  assign core_addr_b  = elem_hs ? wr_addr : '0;
  assign core_wdata_a = elem_hs ? elem_a : '0;
  assign core_wdata_b = elem_hs ? elem_b : '0;

  assign cmd_ready        = cmd_ready_q;
  assign elem_ready       = elem_ready_q;
  assign res_valid        = res_valid_q;
  assign res_data         = res_data_q;
  assign res_tmo          = res_tmo_q;
  assign core_r_enable    = r_en_q;
  assign core_control_arr = ctrl_arr_q;
  assign core_init_i      = base_q;
  assign core_init_acc    = acc_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_dot_prod_ctrl.sv
// Bench for dot_prod_ctrl: directed commands against a behavioural core model,
// with result and array-write scoreboards fed by the stimulus tasks.
module tb_dot_prod_ctrl;
  import dot_prod_pkg::*;

  localparam int TMO = 64;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_valid, cmd_ready;
  logic [AW:0]          cmd_len;
  logic signed [RW-1:0] cmd_acc;
  logic                 elem_valid, elem_ready;
  logic signed [DW-1:0] elem_a, elem_b;
  logic                 res_valid, res_ready;
  logic signed [RW-1:0] res_data;
  logic                 res_tmo;
  logic                 core_r_enable, core_control_arr;
  logic [AW-1:0]        core_init_i;
  logic signed [RW-1:0] core_init_acc;
  logic                 core_we_a, core_we_b;
  logic [AW-1:0]        core_addr_a, core_addr_b;
  logic signed [DW-1:0] core_wdata_a, core_wdata_b;
  logic                 core_w_enable = 1'b0;
  logic signed [RW-1:0] core_result = '0;
  state_t               state_o;

  always #5 clk = ~clk;

  dot_prod_ctrl #(.TMO(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_len          (cmd_len),
    .cmd_acc          (cmd_acc),
    .elem_valid       (elem_valid),
    .elem_ready       (elem_ready),
    .elem_a           (elem_a),
    .elem_b           (elem_b),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_tmo          (res_tmo),
    .core_r_enable    (core_r_enable),
    .core_control_arr (core_control_arr),
    .core_init_i      (core_init_i),
    .core_init_acc    (core_init_acc),
    .core_we_a        (core_we_a),
    .core_we_b        (core_we_b),
    .core_addr_a      (core_addr_a),
    .core_addr_b      (core_addr_b),
    .core_wdata_a     (core_wdata_a),
    .core_wdata_b     (core_wdata_b),
    .core_w_enable    (core_w_enable),
    .core_result      (core_result),
    .state_o          (state_o)
  );

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- behavioural core ----------------
  elem_t mem_a [N];
  elem_t mem_b [N];
  logic  hang = 1'b0;
  logic  busy = 1'b0;
  int    lat  = 0;

  function automatic acc_t core_sum(input logic [AW-1:0] i0, input acc_t a0);
    acc_t s = a0;
    for (int i = int'(i0); i < N; i++) s += acc_t'(mem_a[i]) * acc_t'(mem_b[i]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (core_control_arr && core_we_a) mem_a[core_addr_a] <= core_wdata_a;
    if (core_control_arr && core_we_b) mem_b[core_addr_b] <= core_wdata_b;
    if (core_r_enable) begin
      core_w_enable <= 1'b0;
      busy          <= 1'b1;
      lat           <= 0;
      core_result   <= core_sum(core_init_i, core_init_acc);
    end else if (busy && !hang) begin
      if (lat == 4) begin
        core_w_enable <= 1'b1;
        busy          <= 1'b0;
      end else begin
        lat <= lat + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [RW:0]          exp_q [$];
  logic [AW+2*DW-1:0]   wr_q  [$];
  logic [RW:0]          res_e;
  logic [AW+2*DW-1:0]   wr_e;
  int wr_cnt = 0;
  int wait_cycles = 0;

  task automatic check(input string name, input logic [RW:0] act, input logic [RW:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW:0] pack_res(input logic tmo, input acc_t d);
    return {tmo, d};
  endfunction

  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL result_unexpected: got %0h expected none", {res_tmo, res_data});
      end else begin
        res_e = exp_q.pop_front();
        check("result", {res_tmo, res_data}, res_e);
      end
    end
  end

  always @(negedge clk) begin
    if (state_o == ST_WAIT) wait_cycles++;
    if (core_we_a || core_we_b) begin
      wr_cnt++;
      check("we_pair", {core_we_a, core_we_b}, 2'b11);
      check("we_ctrl", core_control_arr, 1'b1);
      if (wr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL write_unexpected: got addr %0d expected none", core_addr_a);
      end else begin
        wr_e = wr_q.pop_front();
        check("wr_a", {core_addr_a, core_wdata_a}, wr_e[AW+2*DW-1:DW]);
        check("wr_b", {core_addr_b, core_wdata_b}, {wr_e[AW+2*DW-1:2*DW], wr_e[DW-1:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [AW:0] len, input acc_t acc);
    int n = 0;
    cmd_len   = len;
    cmd_acc   = acc;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_elem(input logic [AW-1:0] addr, input elem_t a, input elem_t b,
                           input bit gaps);
    int n = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        elem_valid = 1'b0;
        tick();
      end
    end
    elem_a     = a;
    elem_b     = b;
    elem_valid = 1'b1;
    while (!elem_ready && n < 200) begin
      tick();
      n++;
    end
    check("elem_ready_wait", elem_ready, 1'b1);
    wr_q.push_back({addr, a, b});
    tick();
    elem_valid = 1'b0;
  endtask

  task automatic expect_start(input logic [AW-1:0] ii, input acc_t acc);
    int n = 0;
    while (!core_r_enable && n < 100) begin
      tick();
      n++;
    end
    check("start_pulse", core_r_enable, 1'b1);
    check("start_state", state_o, ST_START);
    check("start_ctrl", core_control_arr, 1'b0);
    check("init_i", core_init_i, ii);
    check("init_acc", core_init_acc, acc);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < budget) begin
      tick();
      n++;
    end
    check("result_pending", exp_q.size(), 0);
    check("cmd_ready_after", cmd_ready, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, state_o, ST_IDLE);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check({tag, "_elem_ready"}, elem_ready, 1'b0);
    check({tag, "_ctrl_arr"}, core_control_arr, 1'b1);
    check({tag, "_r_enable"}, core_r_enable, 1'b0);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_res_tmo"}, res_tmo, 1'b0);
    check({tag, "_res_data"}, res_data, '0);
    check({tag, "_we"}, {core_we_a, core_we_b}, 2'b00);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wr0;
    int wt0;
    rst = 1'b1; cmd_valid = 1'b0; elem_valid = 1'b0; res_ready = 1'b1;
    cmd_len = '0; cmd_acc = '0; elem_a = '0; elem_b = '0;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Three pairs at the top of the array: 1*2 + 3*4 - 5*6 = -16.
    wr0 = wr_cnt;
    exp_q.push_back(pack_res(1'b0, -64'sd16));
    send_cmd(11'd3, 64'sd0);
    send_elem(10'd997, 27'sd1, 27'sd2, 1'b0);
    send_elem(10'd998, 27'sd3, 27'sd4, 1'b0);
    send_elem(10'd999, -27'sd5, 27'sd6, 1'b0);
    expect_start(10'd997, 64'sd0);
    drain(200);
    check("t1_writes", wr_cnt - wr0, 3);

    // Empty command: START straight after the command, result is acc.
    wr0 = wr_cnt;
    exp_q.push_back(pack_res(1'b0, 64'sd42));
    send_cmd(11'd0, 64'sd42);
    check("t2_start_next", state_o, ST_START);
    expect_start(10'd1000, 64'sd42);
    drain(200);
    check("t2_writes", wr_cnt - wr0, 0);

    // Full array with random gaps: -1 + 1000*1 = 999.
    wr0 = wr_cnt;
    exp_q.push_back(pack_res(1'b0, 64'sd999));
    send_cmd(11'd1000, -64'sd1);
    for (int k = 0; k < N; k++) send_elem(AW'(k), 27'sd1, 27'sd1, 1'b1);
    expect_start(10'd0, -64'sd1);
    drain(200);
    check("t3_writes", wr_cnt - wr0, 1000);

    // Watchdog: core never completes, result held while res_ready is low.
    hang      = 1'b1;
    res_ready = 1'b0;
    exp_q.push_back(pack_res(1'b1, 64'sd0));
    send_cmd(11'd1, 64'sd7);
    send_elem(10'd999, 27'sd3, 27'sd3, 1'b0);
    expect_start(10'd999, 64'sd7);
    wt0 = wait_cycles;
    for (int n = 0; n < 200 && !res_valid; n++) tick();
    check("t4_res_valid", res_valid, 1'b1);
    check("t4_wait_cycles", wait_cycles - wt0, 64);
    repeat (10) begin
      tick();
      check("t4_hold_valid", res_valid, 1'b1);
      check("t4_hold_tmo", res_tmo, 1'b1);
      check("t4_hold_data", res_data, '0);
      check("t4_hold_cmd_ready", cmd_ready, 1'b0);
    end
    res_ready = 1'b1;
    drain(20);
    hang = 1'b0;

    // Reset in the middle of a load, then a fresh command: 5 - 21 + 100 = 84.
    wr0 = wr_cnt;
    send_cmd(11'd5, 64'sd0);
    send_elem(10'd995, 27'sd1, 27'sd1, 1'b0);
    send_elem(10'd996, 27'sd2, 27'sd2, 1'b0);
    rst = 1'b1;
    tick();
    check_idle("midrst");
    rst = 1'b0;
    check("t5_partial_writes", wr_cnt - wr0, 2);
    exp_q.push_back(pack_res(1'b0, 64'sd84));
    send_cmd(11'd2, 64'sd5);
    send_elem(10'd998, 27'sd7, -27'sd3, 1'b0);
    send_elem(10'd999, 27'sd10, 27'sd10, 1'b0);
    expect_start(10'd998, 64'sd5);
    drain(200);

    // Oversized length saturates to N: base 0, 1000 * (2 * -3) = -6000.
    wr0 = wr_cnt;
    exp_q.push_back(pack_res(1'b0, -64'sd6000));
    send_cmd(11'd1023, 64'sd0);
    for (int k = 0; k < N; k++) send_elem(AW'(k), 27'sd2, -27'sd3, 1'b0);
    expect_start(10'd0, 64'sd0);
    drain(200);
    check("t6_writes", wr_cnt - wr0, 1000);
    check("writes_pending", wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
